// File: rtl/clock_div_ctrl_if.sv
// clock_div_ctrl_if: run control, config handshake and divider outputs
// of clock_div_ctrl. The tick_count member exists only when TICK_CNT_EN is defined.
interface clock_div_ctrl_if #(
    parameter int CNT_W = 17
);
    logic             enable;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             tick;
    logic             div_clock;
    logic             running;
`ifdef TICK_CNT_EN
    logic [15:0]      tick_count;
`endif

    // Requester side: drives run control and config, observes the divider.
    modport master (
        output enable,
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  tick,
        input  div_clock,
`ifdef TICK_CNT_EN
        input  tick_count,
`endif
        input  running
    );

    // Controller side.
    modport slave (
        input  enable,
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output tick,
        output div_clock,
`ifdef TICK_CNT_EN
        output tick_count,
`endif
        output running
    );
endinterface

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: counter-based clock divider controller.
// Generates a one-clock tick every active_div clocks and a 50% div_clock that
// toggles on each tick. enable=0 lets the current period finish (DRAIN) before
// stopping. New ratios arrive over a valid/ready handshake and are only applied
// at a reload edge while counting, so no period is ever shortened or stretched.
// Optional feature macro: TICK_CNT_EN adds a wrapping 16-bit tick_count output.
module clock_div_ctrl #(
    parameter int CNT_W       = 17,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic                 clock,
    input  logic                 reset,
    clock_div_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);

    // Ratios below 2 cannot produce a 50% div_clock; raise them to 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        if (d < CNT_W'(2)) begin
            return CNT_W'(2);
        end else begin
            return d;
        end
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             tick_q, tick_d;
    logic             div_clk_q, div_clk_d;
    logic             running_q, running_d;
    logic             xfer_s;
    logic             reload_s;

    assign xfer_s   = bus.cfg_valid & cfg_ready_q;
    assign reload_s = (cnt_q == ZERO_C);

    // Next-state, counter, config-apply and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_div_d = active_div_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        cfg_ready_d  = cfg_ready_q;
        tick_d       = 1'b0;
        div_clk_d    = div_clk_q;

        // cfg_ready=1 implies nothing is pending, so a transfer never
        // collides with an application below.
        if (xfer_s) begin
            pend_d      = clamp_div(bus.cfg_div);
            pend_vld_d  = 1'b1;
            cfg_ready_d = 1'b0;
        end else begin
            pend_d      = pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_vld_q) begin
                    active_div_d = pend_q;
                    cnt_d        = pend_q - ONE_C;
                    pend_vld_d   = 1'b0;
                    cfg_ready_d  = 1'b1;
                end else begin
                    cnt_d        = active_div_q - ONE_C;
                end
                if (bus.enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (reload_s) begin
                    tick_d    = 1'b1;
                    div_clk_d = ~div_clk_q;
                    // New ratio only becomes the reload value: the period
                    // just finished used the old one.
                    if (pend_vld_q) begin
                        active_div_d = pend_q;
                        cnt_d        = pend_q - ONE_C;
                        pend_vld_d   = 1'b0;
                        cfg_ready_d  = 1'b1;
                    end else begin
                        cnt_d        = active_div_q - ONE_C;
                    end
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
                // RUN with enable low always drains one more (possibly full)
                // period; DRAIN stops at its reload unless re-enabled.
                if (bus.enable) begin
                    state_d = ST_RUN;
                end else if ((state_q == ST_DRAIN) && reload_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = active_div_q - ONE_C;
            end
        endcase

        running_d = (state_d != ST_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= DEF_DIV_C - ONE_C;
            active_div_q <= DEF_DIV_C;
            pend_q       <= DEF_DIV_C;
            pend_vld_q   <= 1'b0;
            cfg_ready_q  <= 1'b1;
            tick_q       <= 1'b0;
            div_clk_q    <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_div_q <= active_div_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            cfg_ready_q  <= cfg_ready_d;
            tick_q       <= tick_d;
            div_clk_q    <= div_clk_d;
            running_q    <= running_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.tick      = tick_q;
    assign bus.div_clock = div_clk_q;
    assign bus.running   = running_q;

`ifdef TICK_CNT_EN
    logic [15:0] tick_cnt_q;

    // Free-running tick counter, wraps naturally and survives IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= 16'd0;
        end else if (tick_d) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end else begin
            tick_cnt_q <= tick_cnt_q;
        end
    end

    assign bus.tick_count = tick_cnt_q;
`endif
endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed testbench for clock_div_ctrl built with DEFAULT_DIV=4.
module tb_clock_div_ctrl;
    localparam int CNT_W = 17;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    clock_div_ctrl_if #(.CNT_W(CNT_W)) bus ();

    clock_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Steps until tick is seen; n = clocks waited, seen = 0 on timeout.
    task automatic wait_tick(input int budget, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            step();
            n++;
            if (bus.tick === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        bus.enable    = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = 17'd0;
        reset         = 1'b0;
        step();
        reset         = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div = 17'd0;
        #1;
        reset = 1'b0;
        #2;
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b exp 0", bus.tick); end
        total++; if (bus.div_clock !== 1'b0) begin bad++; $display("FAIL reset_divclk: got %b exp 0", bus.div_clock); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b exp 0", bus.running); end
        total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready: got %b exp 1", bus.cfg_ready); end
`ifdef TICK_CNT_EN
        total++; if (bus.tick_count !== 16'd0) begin bad++; $display("FAIL reset_tick_count: got %0d exp 0", bus.tick_count); end
`endif
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int n; bit seen;
        do_reset();
        bus.enable = 1'b1;
        step();
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL basic_running: got %b exp 1", bus.running); end
        wait_tick(20, n, seen);
        total++; if (!seen || n != 4) begin bad++; $display("FAIL basic_first_gap: got %0d (seen %0d) exp 4", n, seen); end
        total++; if (bus.div_clock !== 1'b1) begin bad++; $display("FAIL basic_divclk_hi: got %b exp 1", bus.div_clock); end
        wait_tick(20, n, seen);
        total++; if (!seen || n != 4) begin bad++; $display("FAIL basic_second_gap: got %0d (seen %0d) exp 4", n, seen); end
        total++; if (bus.div_clock !== 1'b0) begin bad++; $display("FAIL basic_divclk_lo: got %b exp 0", bus.div_clock); end
`ifdef TICK_CNT_EN
        total++; if (bus.tick_count !== 16'd2) begin bad++; $display("FAIL basic_tick_count: got %0d exp 2", bus.tick_count); end
`endif
    endtask

    task automatic test_cfg_idle();
        int n; bit seen;
        do_reset();
        bus.cfg_valid = 1'b1;
        bus.cfg_div = 17'd6;
        step();
        bus.cfg_valid = 1'b0;
        total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL idle_cfg_ready_low: got %b exp 0", bus.cfg_ready); end
        step();
        total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_cfg_ready_back: got %b exp 1", bus.cfg_ready); end
        bus.enable = 1'b1;
        step();
        wait_tick(20, n, seen);
        total++; if (!seen || n != 6) begin bad++; $display("FAIL idle_cfg_gap1: got %0d (seen %0d) exp 6", n, seen); end
        wait_tick(20, n, seen);
        total++; if (!seen || n != 6) begin bad++; $display("FAIL idle_cfg_gap2: got %0d (seen %0d) exp 6", n, seen); end
    endtask

    task automatic test_cfg_run();
        int n; bit seen;
        do_reset();
        bus.enable = 1'b1;
        step();
        wait_tick(20, n, seen);
        total++; if (!seen || n != 4) begin bad++; $display("FAIL run_cfg_pre_gap: got %0d (seen %0d) exp 4", n, seen); end
        step();
        bus.cfg_valid = 1'b1;
        bus.cfg_div = 17'd3;
        step();
        bus.cfg_div = 17'd5;
        total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL run_cfg_accept: got %b exp 0", bus.cfg_ready); end
        step();
        total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL run_cfg_stall: got %b exp 0", bus.cfg_ready); end
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL run_cfg_no_early_tick: got %b exp 0", bus.tick); end
        step();
        total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL run_cfg_old_period: got %b exp 1", bus.tick); end
        step();
        bus.cfg_valid = 1'b0;
        total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL run_cfg_second_accept: got %b exp 0", bus.cfg_ready); end
        wait_tick(20, n, seen);
        total++; if (!seen || n != 2) begin bad++; $display("FAIL run_cfg_gap3: got %0d (seen %0d) exp 2", n, seen); end
        total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL run_cfg_ready_after_apply: got %b exp 1", bus.cfg_ready); end
        wait_tick(20, n, seen);
        total++; if (!seen || n != 5) begin bad++; $display("FAIL run_cfg_gap5: got %0d (seen %0d) exp 5", n, seen); end
    endtask

    task automatic test_clamp();
        int n; bit seen;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            bus.cfg_valid = 1'b1;
            bus.cfg_div = 17'(v);
            step();
            bus.cfg_valid = 1'b0;
            step();
            bus.enable = 1'b1;
            step();
            wait_tick(20, n, seen);
            total++; if (!seen || n != 2) begin bad++; $display("FAIL clamp%0d_gap1: got %0d (seen %0d) exp 2", v, n, seen); end
            total++; if (bus.div_clock !== 1'b1) begin bad++; $display("FAIL clamp%0d_divclk_hi: got %b exp 1", v, bus.div_clock); end
            wait_tick(20, n, seen);
            total++; if (!seen || n != 2) begin bad++; $display("FAIL clamp%0d_gap2: got %0d (seen %0d) exp 2", v, n, seen); end
            total++; if (bus.div_clock !== 1'b0) begin bad++; $display("FAIL clamp%0d_divclk_lo: got %b exp 0", v, bus.div_clock); end
        end
    endtask

    task automatic test_drain();
        int n; bit seen; logic dc;
        do_reset();
        bus.cfg_valid = 1'b1;
        bus.cfg_div = 17'd5;
        step();
        bus.cfg_valid = 1'b0;
        step();
        bus.enable = 1'b1;
        step();
        wait_tick(20, n, seen);
        total++; if (!seen || n != 5) begin bad++; $display("FAIL drain_pre_gap: got %0d (seen %0d) exp 5", n, seen); end
        step();
        bus.enable = 1'b0;
        step();
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL drain_running: got %b exp 1", bus.running); end
        wait_tick(20, n, seen);
        total++; if (!seen || n != 3) begin bad++; $display("FAIL drain_final_tick: got %0d (seen %0d) exp 3", n, seen); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL drain_stopped: got %b exp 0", bus.running); end
        dc = bus.div_clock;
        wait_tick(20, n, seen);
        total++; if (seen) begin bad++; $display("FAIL drain_extra_tick: got tick after %0d clocks exp none", n); end
        total++; if (bus.div_clock !== dc) begin bad++; $display("FAIL drain_divclk_hold: got %b exp %b", bus.div_clock, dc); end
        // Re-assert enable while draining.
        bus.enable = 1'b1;
        step();
        wait_tick(20, n, seen);
        total++; if (!seen || n != 5) begin bad++; $display("FAIL redrain_pre_gap: got %0d (seen %0d) exp 5", n, seen); end
        step();
        bus.enable = 1'b0;
        step();
        bus.enable = 1'b1;
        step();
        wait_tick(20, n, seen);
        total++; if (!seen || n != 2) begin bad++; $display("FAIL redrain_gap: got %0d (seen %0d) exp 2", n, seen); end
        wait_tick(20, n, seen);
        total++; if (!seen || n != 5) begin bad++; $display("FAIL redrain_next_gap: got %0d (seen %0d) exp 5", n, seen); end
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL redrain_running: got %b exp 1", bus.running); end
    endtask

    task automatic test_async_reset();
        int n; bit seen;
        do_reset();
        bus.enable = 1'b1;
        step();
        wait_tick(20, n, seen);
        total++; if (!seen || bus.div_clock !== 1'b1) begin bad++; $display("FAIL areset_setup: got seen=%0d divclk=%b exp 1/1", seen, bus.div_clock); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL areset_tick: got %b exp 0", bus.tick); end
        total++; if (bus.div_clock !== 1'b0) begin bad++; $display("FAIL areset_divclk: got %b exp 0", bus.div_clock); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL areset_running: got %b exp 0", bus.running); end
        total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL areset_cfg_ready: got %b exp 1", bus.cfg_ready); end
        bus.enable = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_cfg_idle();
        test_cfg_run();
        test_clamp();
        test_drain();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
